ntt_frame_serializer: RTL and testbench
=======================================

Name: ntt_frame_serializer

Overview:
- Sink for the NTT pipeline output. It captures a full N-coefficient parallel frame on a one-cycle valid strobe and replays it as a coefficient-per-beat stream under a valid/ready handshake.
- Sits between ntt_block_radix2_pipelined (Data_out/data_valid_out/mode_out) and downstream memory or a PCIe/DMA writer.
- The NTT has no backpressure, so the block provides 2-frame ping-pong buffering, plus drop detection when that buffering is exceeded.

Parameters:
- W, 32, coefficient width in bits.
- N, 8, coefficients per frame; power of two, at least 2.
- DROP_CNT_W, 8, width of the saturating dropped-frame counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- frame_valid  input  1  one-cycle strobe; frame_data is valid this cycle (driven by the NTT data_valid_out).
- frame_mode  input  1  0 = NTT result, 1 = iNTT result; captured with the frame.
- frame_data  input  W x [0:N-1]  unpacked coefficient array.
- coef_valid  output  1  stream beat valid.
- coef_ready  input  1  downstream accepts the beat when high together with coef_valid.
- coef_data  output  W  current coefficient.
- coef_index  output  $clog2(N)  natural-order index of coef_data.
- coef_last  output  1  high on beat N-1 of a frame.
- coef_mode  output  1  mode captured with the frame being streamed.
- overflow  output  1  sticky flag; set when a frame is dropped.
- drop_count  output  DROP_CNT_W  saturating count of dropped frames.
- busy  output  1  high when at least one frame is buffered.

Behaviour:
- Reset (async assert, sync-safe deassert): all outputs are 0; both slots are empty; wr_ptr = rd_ptr = 0; beat = 0; state = IDLE.
- Storage: 2 slots, each holding N x W data plus 1 mode bit. Tracking: occupancy count 0..2, wr_ptr, rd_ptr (1 bit each), beat counter of $clog2(N) bits.
- Capture: on frame_valid with count < 2, write frame_data and frame_mode into slot wr_ptr, toggle wr_ptr, increment count.
- Capture latency: frame_valid sampled at edge k makes coef_valid high after edge k. First beat is visible in cycle k+1 when the block was IDLE.
- State IDLE: coef_valid = 0. Move to STREAM when count becomes nonzero.
- State STREAM: coef_valid = 1.
  - coef_data = slot[rd_ptr][beat]; coef_index = beat; coef_mode = mode[rd_ptr]; coef_last = (beat == N-1).
  - All of these are derived from registered state only; no combinational path from frame_* to coef_*.
- Handshake: coef_data, coef_index, coef_last and coef_mode are held stable while coef_valid && !coef_ready. coef_valid never drops without a transfer.
- Transfer (coef_valid && coef_ready):
  - beat < N-1: increment beat.
  - beat == N-1: beat = 0, toggle rd_ptr, decrement count. Go to IDLE if the resulting count is 0; otherwise stay in STREAM with no bubble, so the next frame's beat 0 appears the following cycle.
- Simultaneous capture and last-beat transfer:
  - With count == 2: the frame is ACCEPTED, because the slot is freed in the same cycle. Write goes into the slot being released (wr_ptr == rd_ptr). Count stays 2. No drop.
  - With count == 1: count stays 1 and streaming continues.
- Overflow: frame_valid with count == 2 and no same-cycle last-beat transfer drops the frame.
  - Buffer contents are untouched.
  - overflow is set (sticky until reset).
  - drop_count increments, saturating at 2^DROP_CNT_W-1.
- busy = (count != 0).
- Reset mid-stream: an in-flight frame is discarded and coef_valid goes low immediately (asynchronously).
- Data is passed through unmodified; no modular reduction is applied.

Optional Feature:
- Macro: NTT_SER_BITREV_EN.
- Defined: read order is bit-reversed. coef_data = slot[rd_ptr][bitrev(beat)] and coef_index = bitrev(beat), so natural-order output comes from a DIT pipeline. coef_last is still tied to beat == N-1.
- Undefined: natural order, coef_index = beat. No bit-reversal logic is synthesized.

Test Plan:
- Single frame, N=8, frame_data = {123412341, 123412342, 123412343, 123412344, 123412345, 0, 0, 0}, mode 0, coef_ready held 1 -> beats 1..8 after the strobe carry those values with index 0..7, coef_last only on index 7, coef_mode 0, busy drops the cycle after the last beat.
- Backpressure: same frame, coef_ready toggled 1,0,0,1,... -> each beat is held stable while ready is low, no beat is lost or duplicated, exactly 8 transfers.
- Back-to-back: two strobes 1 cycle apart (mode 0, then mode 1), ready = 1 -> 16 contiguous beats with no bubble; coef_mode switches to 1 at beat 8.
- Overflow: ready = 0, three strobes -> frames 1 and 2 are retained, frame 3 is dropped, overflow = 1, drop_count = 1. Raising ready then streams frames 1 and 2 only.
- Simultaneous: count = 2 and a strobe lands in the same cycle as the last-beat transfer -> frame accepted, overflow stays 0, all three frames stream in order.
- Reset mid-stream: assert reset_n = 0 at beat 3 -> all outputs are 0 asynchronously. After release, a new frame streams from index 0.
- With NTT_SER_BITREV_EN defined, input {0..7} -> coef_index sequence 0, 4, 2, 6, 1, 5, 3, 7 with coef_data equal to coef_index.

Source files
------------

// File: rtl/ntt_frame_serializer.sv
// ---------------------------------------------------------------------------
// ntt_frame_serializer
//
// Purpose:
//   Output sink for the NTT pipeline. A full N-coefficient frame is captured
//   on a one-cycle strobe into one of two ping-pong slots. The frame is then
//   replayed one coefficient per beat over a valid/ready stream. The NTT
//   cannot be stalled, so a strobe that arrives while both slots are full is
//   dropped. The drop is recorded in a sticky flag and in a saturating counter.
//
// Configuration macro:
//   NTT_SER_BITREV_EN - when defined, slots are read in bit-reversed order
//                       (coef_index = bitrev(beat)). This restores natural
//                       order for a DIT pipeline. When undefined, the read
//                       order is natural.
//
// Ports:
//   clk          in   clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   frame_valid  in   one-cycle frame strobe
//   frame_mode   in   0 = NTT, 1 = iNTT; captured with the frame
//   frame_data   in   W x [0:N-1] coefficient frame
//   coef_valid   out  stream beat valid
//   coef_ready   in   downstream ready
//   coef_data    out  current coefficient
//   coef_index   out  index of coef_data within the frame
//   coef_last    out  high on the final beat of a frame
//   coef_mode    out  mode of the frame being streamed
//   overflow     out  sticky dropped-frame flag
//   drop_count   out  saturating dropped-frame count
//   busy         out  at least one frame buffered
// ---------------------------------------------------------------------------
module ntt_frame_serializer #(
   parameter int W          = 32,
   parameter int N          = 8,
   parameter int DROP_CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    frame_valid,
   input  logic                    frame_mode,
   input  logic [W-1:0]            frame_data [0:N-1],
   output logic                    coef_valid,
   input  logic                    coef_ready,
   output logic [W-1:0]            coef_data,
   output logic [$clog2(N)-1:0]    coef_index,
   output logic                    coef_last,
   output logic                    coef_mode,
   output logic                    overflow,
   output logic [DROP_CNT_W-1:0]   drop_count,
   output logic                    busy
);

   localparam int IDX_W = $clog2(N);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   state_t                 r_state;
   logic [W-1:0]           r_slot [0:1][0:N-1];
   logic                   r_mode [0:1];
   logic [1:0]             r_count;
   logic                   r_wr_ptr;
   logic                   r_rd_ptr;
   logic [IDX_W-1:0]       r_beat;
   logic                   r_overflow;
   logic [DROP_CNT_W-1:0]  r_drop_count;

   logic                   w_xfer;
   logic                   w_last_beat;
   logic                   w_last_xfer;
   logic                   w_accept;
   logic                   w_drop;
   logic [1:0]             w_count_next;
   logic [IDX_W-1:0]       w_rd_idx;

   assign w_xfer      = (r_state == ST_STREAM) && coef_ready;
   assign w_last_beat = (r_beat == IDX_W'(N - 1));
   assign w_last_xfer = w_xfer && w_last_beat;

   // A full buffer still accepts a frame when the last beat leaves in the
   // same cycle. Both slots are full in that case, so wr_ptr == rd_ptr and
   // the write lands in the slot that is being released.
   assign w_accept     = frame_valid && ((r_count != 2'd2) || w_last_xfer);
   assign w_drop       = frame_valid && !w_accept;
   assign w_count_next = r_count + {1'b0, w_accept} - {1'b0, w_last_xfer};

`ifdef NTT_SER_BITREV_EN
   genvar gi;
   generate
      for (gi = 0; gi < IDX_W; gi++) begin : g_bitrev
         assign w_rd_idx[gi] = r_beat[IDX_W-1-gi];
      end
   endgenerate
`else
   assign w_rd_idx = r_beat;
`endif

   // Control path, reset asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_count      <= 2'd0;
         r_wr_ptr     <= 1'b0;
         r_rd_ptr     <= 1'b0;
         r_beat       <= '0;
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else begin
         r_count <= w_count_next;

         if (w_accept)
            r_wr_ptr <= ~r_wr_ptr;

         if (w_xfer) begin
            if (w_last_beat) begin
               r_beat   <= '0;
               r_rd_ptr <= ~r_rd_ptr;
            end else begin
               r_beat <= r_beat + 1'b1;
            end
         end

         // The state follows the next occupancy. A captured frame is therefore
         // visible in the cycle after the strobe, and back-to-back frames
         // stream without a bubble.
         case (r_state)
            ST_IDLE:   if (w_count_next != 2'd0) r_state <= ST_STREAM;
            ST_STREAM: if (w_count_next == 2'd0) r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
         endcase

         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != {DROP_CNT_W{1'b1}})
               r_drop_count <= r_drop_count + 1'b1;
         end
      end
   end

   // Frame storage. It has no reset: outputs are gated by the stream state,
   // so stale contents are never exposed.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int i = 0; i < N; i++)
            r_slot[r_wr_ptr][i] <= frame_data[i];
         r_mode[r_wr_ptr] <= frame_mode;
      end
   end

   assign coef_valid = (r_state == ST_STREAM);
   assign coef_data  = coef_valid ? r_slot[r_rd_ptr][w_rd_idx] : '0;
   assign coef_index = coef_valid ? w_rd_idx : '0;
   assign coef_mode  = coef_valid ? r_mode[r_rd_ptr] : 1'b0;
   assign coef_last  = coef_valid && w_last_beat;
   assign overflow   = r_overflow;
   assign drop_count = r_drop_count;
   assign busy       = (r_count != 2'd0);

endmodule

// File: tb/tb_ntt_frame_serializer.sv
// ---------------------------------------------------------------------------
// tb_ntt_frame_serializer
//
// Purpose:
//   Directed testbench for ntt_frame_serializer with N = 8 and W = 32. The
//   stimulus covers a single frame, backpressure, back-to-back frames,
//   overflow/drop, a capture that coincides with the last beat, a reset in
//   the middle of a stream, and (under NTT_SER_BITREV_EN) bit-reversed read
//   order.
// Ports: none.
// ---------------------------------------------------------------------------
module tb_ntt_frame_serializer;

   localparam int W = 32;
   localparam int N = 8;
   localparam int D = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          frame_valid;
   logic          frame_mode;
   logic [W-1:0]  frame_data [0:N-1];
   logic          coef_valid;
   logic          coef_ready;
   logic [W-1:0]  coef_data;
   logic [2:0]    coef_index;
   logic          coef_last;
   logic          coef_mode;
   logic          overflow;
   logic [D-1:0]  drop_count;
   logic          busy;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp1 [0:7] = '{32'd123412341, 32'd123412342, 32'd123412343,
                              32'd123412344, 32'd123412345, 32'd0, 32'd0, 32'd0};

   ntt_frame_serializer #(.W(W), .N(N), .DROP_CNT_W(D)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .frame_valid (frame_valid),
      .frame_mode  (frame_mode),
      .frame_data  (frame_data),
      .coef_valid  (coef_valid),
      .coef_ready  (coef_ready),
      .coef_data   (coef_data),
      .coef_index  (coef_index),
      .coef_last   (coef_last),
      .coef_mode   (coef_mode),
      .overflow    (overflow),
      .drop_count  (drop_count),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one clock and land 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int base, input logic mode);
      for (int i = 0; i < N; i++) frame_data[i] = W'(base + i);
      frame_mode  = mode;
      frame_valid = 1'b1;
   endtask

   task automatic check_beat(input string tag, input logic [31:0] d, input int idx,
                             input logic mode);
      check({tag, " valid"}, {63'd0, coef_valid}, 64'd1);
      check({tag, " data"},  {32'd0, coef_data}, {32'd0, d});
      check({tag, " index"}, {61'd0, coef_index}, 64'(idx));
      check({tag, " last"},  {63'd0, coef_last}, {63'd0, (idx == N - 1)});
      check({tag, " mode"},  {63'd0, coef_mode}, {63'd0, mode});
      $display("beat %s data=%0d index=%0d last=%0b mode=%0b", tag, coef_data, coef_index,
               coef_last, coef_mode);
   endtask

   task automatic check_idle(input string tag);
      check({tag, " valid"}, {63'd0, coef_valid}, 64'd0);
      check({tag, " data"},  {32'd0, coef_data}, 64'd0);
      check({tag, " index"}, {61'd0, coef_index}, 64'd0);
      check({tag, " last"},  {63'd0, coef_last}, 64'd0);
      check({tag, " mode"},  {63'd0, coef_mode}, 64'd0);
      check({tag, " busy"},  {63'd0, busy}, 64'd0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   initial begin
      int xfers;
      int cyc;
      logic rdy_pat [0:3];
      rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b1;

      reset_n     = 1'b0;
      frame_valid = 1'b0;
      frame_mode  = 1'b0;
      coef_ready  = 1'b0;
      for (int i = 0; i < N; i++) frame_data[i] = '0;
      #2;
      check_idle("reset");
      check("reset overflow", {63'd0, overflow}, 64'd0);
      check("reset drop_count", {56'd0, drop_count}, 64'd0);
      step();
      reset_n = 1'b1;
      step();

      // Single frame, ready held high.
      for (int i = 0; i < N; i++) frame_data[i] = exp1[i];
      frame_mode  = 1'b0;
      frame_valid = 1'b1;
      coef_ready  = 1'b1;
      step();
      frame_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         check_beat($sformatf("single%0d", k), exp1[k], k, 1'b0);
         check("single busy", {63'd0, busy}, 64'd1);
         step();
      end
      check_idle("single end");

      // Backpressure, ready pattern 1,0,0,1 repeating.
      for (int i = 0; i < N; i++) frame_data[i] = exp1[i];
      frame_mode  = 1'b0;
      frame_valid = 1'b1;
      coef_ready  = 1'b0;
      step();
      frame_valid = 1'b0;
      xfers = 0;
      cyc   = 0;
      while (xfers < N && cyc < 64) begin
         coef_ready = rdy_pat[cyc % 4];
         check_beat($sformatf("bp c%0d", cyc), exp1[xfers], xfers, 1'b0);
         if (coef_ready) xfers++;
         cyc++;
         step();
      end
      check("bp transfers", 64'(xfers), 64'd8);
      check_idle("bp end");

      // Back-to-back strobes one cycle apart, modes 0 then 1.
      coef_ready = 1'b1;
      load(100, 1'b0);
      step();
      for (int k = 0; k < 2 * N; k++) begin
         if (k == 0) load(200, 1'b1);
         if (k == 1) frame_valid = 1'b0;
         check_beat($sformatf("b2b%0d", k),
                    (k < N) ? 32'(100 + k) : 32'(200 + k - N), k % N, (k >= N));
         step();
      end
      check_idle("b2b end");

      // Overflow: three strobes with ready low, the third is dropped.
      coef_ready = 1'b0;
      load(300, 1'b0);
      step();
      load(400, 1'b1);
      step();
      check("ovf before", {63'd0, overflow}, 64'd0);
      load(500, 1'b0);
      step();
      frame_valid = 1'b0;
      check("ovf flag", {63'd0, overflow}, 64'd1);
      check("ovf drop_count", {56'd0, drop_count}, 64'd1);
      check_beat("ovf hold", 32'd300, 0, 1'b0);
      step();
      check_beat("ovf hold2", 32'd300, 0, 1'b0);
      coef_ready = 1'b1;
      for (int k = 0; k < 2 * N; k++) begin
         check_beat($sformatf("ovf%0d", k),
                    (k < N) ? 32'(300 + k) : 32'(400 + k - N), k % N, (k >= N));
         step();
      end
      check_idle("ovf end");
      check("ovf sticky", {63'd0, overflow}, 64'd1);
      check("ovf count kept", {56'd0, drop_count}, 64'd1);

      // Capture coinciding with the last-beat transfer while both slots are full.
      do_reset();
      check("sim reset overflow", {63'd0, overflow}, 64'd0);
      check("sim reset drop", {56'd0, drop_count}, 64'd0);
      coef_ready = 1'b0;
      load(600, 1'b0);
      step();
      load(700, 1'b1);
      step();
      frame_valid = 1'b0;
      coef_ready  = 1'b1;
      for (int k = 0; k < 3 * N; k++) begin
         if (k == N - 1) load(800, 1'b0);
         if (k == N) frame_valid = 1'b0;
         check_beat($sformatf("sim%0d", k),
                    (k < N) ? 32'(600 + k) : (k < 2 * N) ? 32'(700 + k - N) : 32'(800 + k - 2 * N),
                    k % N, (k >= N && k < 2 * N));
         step();
      end
      check_idle("sim end");
      check("sim overflow", {63'd0, overflow}, 64'd0);
      check("sim drop", {56'd0, drop_count}, 64'd0);

      // Reset in the middle of a stream, asserted between clock edges.
      coef_ready = 1'b1;
      load(900, 1'b1);
      step();
      frame_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check_beat($sformatf("rst%0d", k), 32'(900 + k), k, 1'b1);
         if (k < 3) step();
      end
      #2;
      reset_n = 1'b0;
      #1;
      check_idle("async reset");
      step();
      step();
      reset_n = 1'b1;
      step();
      check_idle("post reset");
      load(1000, 1'b0);
      step();
      frame_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         check_beat($sformatf("after%0d", k), 32'(1000 + k), k, 1'b0);
         step();
      end
      check_idle("after end");

`ifdef NTT_SER_BITREV_EN
      begin
         int brv [0:7];
         brv = '{0, 4, 2, 6, 1, 5, 3, 7};
         load(0, 1'b0);
         step();
         frame_valid = 1'b0;
         for (int k = 0; k < N; k++) begin
            check($sformatf("brev%0d index", k), {61'd0, coef_index}, 64'(brv[k]));
            check($sformatf("brev%0d data", k), {32'd0, coef_data}, 64'(brv[k]));
            check($sformatf("brev%0d last", k), {63'd0, coef_last}, {63'd0, (k == N - 1)});
            $display("brev beat %0d index=%0d data=%0d", k, coef_index, coef_data);
            step();
         end
         check_idle("brev end");
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
